// File: rtl/pipe_pkg.sv
// Shared definitions for the valid/ready pipeline stage: the state encoding and
// the default NOP payload.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } pipe_state_e;

  // The ISA NOP is all zeros; a stage of any width replicates this bit.
  localparam logic NOP_BIT = 1'b0;

endpackage

// File: rtl/dffe_w.sv
// Parametrised register with enable, asynchronous active-high reset and a
// configurable reset value.
module dffe_w #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a two-entry skid buffer: in_ready is decoded
// from state alone, so backpressure never ripples combinationally upstream.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = 16,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{NOP_BIT}},
  parameter int               CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [1:0]       state_raw;
  pipe_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
  logic             main_en, skid_en;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_en, stall;

  assign state_q = pipe_state_e'(state_raw);

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    if (flush) begin
      // Squash beats everything, including a payload offered this cycle.
      state_d = ST_EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
      main_en = 1'b1;
      skid_en = 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_valid) begin
            main_d  = in_data;
            main_en = 1'b1;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (in_valid && out_ready) begin
            main_d  = in_data;
            main_en = 1'b1;
          end else if (in_valid) begin
            skid_d  = in_data;
            skid_en = 1'b1;
            state_d = ST_FULL;
          end else if (out_ready) begin
            main_d  = BUBBLE;
            main_en = 1'b1;
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so in_valid is ignored.
          if (out_ready) begin
            main_d  = skid_q;
            skid_d  = BUBBLE;
            main_en = 1'b1;
            skid_en = 1'b1;
            state_d = ST_BUSY;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
          main_en = 1'b1;
          skid_en = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    stall  = out_valid & ~out_ready;
    cnt_en = clr_stats | (stall & ~(&cnt_q));
    cnt_d  = clr_stats ? '0 : cnt_q + CNT_W'(1);
  end

  always_comb begin
    unique case (state_q)
      ST_BUSY: occupancy = 2'd1;
      ST_FULL: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (state_q != ST_FULL);
  assign out_data  = main_q;
  assign stall_cnt = cnt_q;

  dffe_w #(.WIDTH(2), .RST_VAL(ST_EMPTY)) u_state (
    .clk(clk), .rst(rst), .en(1'b1), .d(state_d), .q(state_raw)
  );

  dffe_w #(.WIDTH(WIDTH), .RST_VAL(BUBBLE)) u_main (
    .clk(clk), .rst(rst), .en(main_en), .d(main_d), .q(main_q)
  );

  dffe_w #(.WIDTH(WIDTH), .RST_VAL(BUBBLE)) u_skid (
    .clk(clk), .rst(rst), .en(skid_en), .d(skid_d), .q(skid_q)
  );

  dffe_w #(.WIDTH(CNT_W), .RST_VAL('0)) u_cnt (
    .clk(clk), .rst(rst), .en(cnt_en), .d(cnt_d), .q(cnt_q)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and random bench for pipe_stage_skid with a FIFO scoreboard model.
module tb_pipe_stage_skid;

  localparam int          WIDTH   = 16;
  localparam int          CNT_W   = 3;
  localparam logic [15:0] BUB     = 16'h0000;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] in_data, out_data;
  logic             flush, clr_stats;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] exp_q[$];
  int exp_cnt = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.WIDTH(WIDTH), .BUBBLE(BUB), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .occupancy(occupancy),
    .clr_stats(clr_stats), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare current outputs with the model, advance the model using the
  // inputs as they stand before the edge, then step one clock.
  task automatic tick();
    int sz;
    logic [31:0] exp_data;
    sz = exp_q.size();
    exp_data = (sz != 0) ? {16'h0, exp_q[0]} : {16'h0, BUB};
    chk("occupancy", {30'h0, occupancy}, sz);
    chk("out_valid", {31'h0, out_valid}, {31'h0, sz != 0});
    chk("in_ready",  {31'h0, in_ready},  {31'h0, sz != 2});
    chk("out_data",  {16'h0, out_data},  exp_data);
    chk("stall_cnt", {29'h0, stall_cnt}, exp_cnt);
    if (clr_stats) exp_cnt = 0;
    else if (sz != 0 && !out_ready && exp_cnt != CNT_MAX) exp_cnt++;
    if (sz != 0 && out_ready) void'(exp_q.pop_front());
    if (flush) exp_q.delete();
    else if (in_valid && sz != 2) exp_q.push_back(in_data);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    flush = 1'b0; clr_stats = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick(); tick();

    // Streaming at full throughput
    drive(1, 16'h1111, 1); tick();
    drive(1, 16'h2222, 1); tick();
    drive(1, 16'h3333, 1); tick();
    drive(0, 16'h0000, 1); tick(); tick();
    chk("stream_stall", {29'h0, stall_cnt}, 0);

    // Backpressure into FULL
    drive(1, 16'hAAAA, 0); tick();
    drive(1, 16'hBBBB, 0); tick();
    drive(0, 16'h0000, 0); tick(); tick(); tick();
    chk("bp_occ", {30'h0, occupancy}, 2);
    chk("bp_data", {16'h0, out_data}, 32'h0000AAAA);
    chk("bp_stall", {29'h0, stall_cnt}, 4);
    // in_ready must not follow out_ready combinationally
    out_ready = 1'b1; #1;
    chk("ready_comb", {31'h0, in_ready}, 0);
    out_ready = 1'b0; #1;
    drive(0, 16'h0000, 1); tick(); tick(); tick();

    // Flush while FULL with a payload offered
    drive(1, 16'hAAAA, 0); tick();
    drive(1, 16'hBBBB, 0); tick();
    drive(1, 16'hCCCC, 0); flush = 1'b1; tick();
    flush = 1'b0;
    chk("flush_data", {16'h0, out_data}, {16'h0, BUB});
    chk("flush_occ", {30'h0, occupancy}, 0);
    chk("flush_stall", {29'h0, stall_cnt}, 6);
    drive(0, 16'h0000, 1); tick(); tick();

    // Flush in BUSY together with a downstream accept
    drive(1, 16'hDDDD, 1); tick();
    drive(0, 16'h0000, 1); flush = 1'b1; tick();
    flush = 1'b0; tick();

    // Saturation and clear
    clr_stats = 1'b1; tick(); clr_stats = 1'b0;
    drive(1, 16'h5A5A, 0); tick();
    drive(0, 16'h0000, 0);
    repeat (10) tick();
    chk("sat", {29'h0, stall_cnt}, 7);
    clr_stats = 1'b1; tick();
    chk("clr", {29'h0, stall_cnt}, 0);
    clr_stats = 1'b0; tick();
    chk("clr_inc", {29'h0, stall_cnt}, 1);
    drive(0, 16'h0000, 1); tick(); tick();

    // Random soak
    for (int i = 0; i < 10000; i++) begin
      in_valid  = $urandom_range(0, 1) == 1;
      in_data   = WIDTH'($urandom);
      out_ready = $urandom_range(0, 2) != 0;
      flush     = $urandom_range(0, 63) == 0;
      clr_stats = $urandom_range(0, 127) == 0;
      tick();
    end
    drive(0, 16'h0000, 1); flush = 1'b0; clr_stats = 1'b0;
    tick(); tick(); tick();

    // Asynchronous reset mid-transfer
    drive(1, 16'h7777, 0); tick();
    drive(1, 16'h8888, 0); tick();
    drive(0, 16'h0000, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", {31'h0, out_valid}, 0);
    chk("rst_ready", {31'h0, in_ready}, 1);
    chk("rst_data", {16'h0, out_data}, {16'h0, BUB});
    exp_q.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
